// File: rtl/addsub_result_accumulator_pkg.sv
// Shared types for the add/sub result accumulator: frame FSM states and
// the add/subtract mode encodings used by the term decoder.
package addsub_result_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_term_decode.sv
// Maps one 4-bit add/sub stage result {m, cout, r} to a signed 6-bit term:
// add -> +{cout,r}, subtract with borrow-free carry -> +r, otherwise -r.
module addsub_term_decode
  import addsub_result_accumulator_pkg::*;
(
  input  logic              m,
  input  logic              cout,
  input  logic [3:0]        r,
  output logic signed [5:0] term
);

  // Carry-out in subtract mode means the true difference was non-negative.
  always_comb begin
    term = 6'sd0;
    case ({m, cout})
      {MODE_ADD, 1'b0}: term = {2'b00, r};
      {MODE_ADD, 1'b1}: term = {2'b01, r};
      {MODE_SUB, 1'b1}: term = {2'b00, r};
      {MODE_SUB, 1'b0}: term = -$signed({2'b00, r});
      default:          term = 6'sd0;
    endcase
  end

endmodule

// File: rtl/addsub_result_accumulator.sv
// Sums FRAME_LEN add/sub results per frame and presents the signed sum with a
// sticky overflow flag. Define ACC_SATURATE_EN to clamp instead of wrap.
module addsub_result_accumulator
  import addsub_result_accumulator_pkg::*;
#(
  parameter int FRAME_LEN = 4,
  parameter int ACC_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_r,
  input  logic                    in_cout,
  input  logic                    in_m,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_ovf
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        count;
  logic                    ovf;

  logic signed [5:0]       term;
  logic signed [ACC_W:0]   term_ext;
  logic signed [ACC_W:0]   sum_wide;
  logic                    step_ovf;
  logic signed [ACC_W-1:0] acc_next;
  logic                    ovf_next;
  logic                    accept;

  addsub_term_decode u_term_decode (
    .m    (in_m),
    .cout (in_cout),
    .r    (in_r),
    .term (term)
  );

  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready && !clear;

  // One extra bit of headroom exposes overflow as a mismatch of the top two bits.
  always_comb begin
    term_ext = {{(ACC_W-5){term[5]}}, term};
    sum_wide = {acc[ACC_W-1], acc} + term_ext;
    step_ovf = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    ovf_next = ovf | step_ovf;
`ifdef ACC_SATURATE_EN
    if (step_ovf) begin
      acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next = sum_wide[ACC_W-1:0];
    end
`else
    acc_next = sum_wide[ACC_W-1:0];
`endif
  end

  // Frame FSM and accumulator; rst beats clear, clear beats both handshakes.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc   <= acc_next;
            ovf   <= ovf_next;
            count <= count + CNT_ONE;
            if (count == CNT_LAST) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_sum   <= acc_next;
              out_ovf   <= ovf_next;
            end else begin
              state <= ACC;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          acc       <= '0;
          count     <= '0;
          ovf       <= 1'b0;
          out_valid <= 1'b0;
          out_sum   <= '0;
          out_ovf   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_result_accumulator.sv
// Directed bench: an 8-bit and a 6-bit accumulator share all inputs, so they
// step through identical frame handshakes while their sums differ in range.
module tb_addsub_result_accumulator;

  logic clk = 1'b0;
  logic rst, in_valid, in_cout, in_m, clear, out_ready;
  logic [3:0] in_r;
  logic in_ready8, out_valid8, out_ovf8;
  logic in_ready6, out_valid6, out_ovf6;
  logic signed [7:0] out_sum8;
  logic signed [5:0] out_sum6;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addsub_result_accumulator #(.FRAME_LEN(4), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_r(in_r), .in_cout(in_cout), .in_m(in_m), .clear(clear),
    .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8),
    .out_ovf(out_ovf8)
  );

  addsub_result_accumulator #(.FRAME_LEN(4), .ACC_W(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6),
    .in_r(in_r), .in_cout(in_cout), .in_m(in_m), .clear(clear),
    .out_valid(out_valid6), .out_ready(out_ready), .out_sum(out_sum6),
    .out_ovf(out_ovf6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic m, input logic c, input logic [3:0] r);
    in_valid = 1'b1;
    in_m     = m;
    in_cout  = c;
    in_r     = r;
  endtask

  task automatic handshake();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_cout = 1'b0; in_m = 1'b0; in_r = 4'd0;
    clear = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_out_valid", out_valid8, 0);
    check("reset_out_sum", out_sum8, 0);
    check("reset_out_ovf", out_ovf8, 0);
    check("reset_in_ready", in_ready8, 1);

    // Four +30 terms.
    drive(1'b0, 1'b1, 4'd14);
    tick(); tick(); tick();
    check("f1_not_yet_valid", out_valid8, 0);
    check("f1_ready_in_acc", in_ready8, 1);
    tick();
    check("f1_out_valid", out_valid8, 1);
    check("f1_out_sum", out_sum8, 120);
    check("f1_out_ovf", out_ovf8, 0);
    check("f1_in_ready_hold", in_ready8, 0);
    handshake();
    check("f1_valid_drops", out_valid8, 0);
    check("f1_ready_back", in_ready8, 1);

    // +30, -15, +5, 0.
    drive(1'b0, 1'b1, 4'd14);  tick();
    drive(1'b1, 1'b0, 4'd15);  tick();
    drive(1'b1, 1'b1, 4'd5);   tick();
    drive(1'b0, 1'b0, 4'd0);   tick();
    in_valid = 1'b0;
    check("f2_out_valid", out_valid8, 1);
    check("f2_out_sum", out_sum8, 20);
    check("f2_out_ovf", out_ovf8, 0);
    check("f2_out_sum6", out_sum6, 20);
    handshake();

    // +30, +30, 0, 0: overflows only the 6-bit accumulator.
    drive(1'b0, 1'b1, 4'd14);  tick(); tick();
    drive(1'b0, 1'b0, 4'd0);   tick(); tick();
    in_valid = 1'b0;
    check("f3_out_sum8", out_sum8, 60);
    check("f3_out_ovf8", out_ovf8, 0);
`ifdef ACC_SATURATE_EN
    check("f3_out_sum6_sat", out_sum6, 31);
`else
    check("f3_out_sum6_wrap", out_sum6, -4);
`endif
    check("f3_out_ovf6", out_ovf6, 1);
    handshake();
    check("f3_ovf6_cleared", out_ovf6, 0);

    // Back-pressure: full +1 frame, consumer stalls while inputs keep coming.
    drive(1'b1, 1'b1, 4'd1);
    tick(); tick(); tick(); tick();
    drive(1'b0, 1'b1, 4'd14);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_in_ready", in_ready8, 0);
      check("bp_out_valid", out_valid8, 1);
      check("bp_out_sum", out_sum8, 4);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_exit_valid", out_valid8, 0);
    check("bp_exit_ready", in_ready8, 1);
    drive(1'b1, 1'b1, 4'd1);
    tick(); tick(); tick(); tick();
    in_valid = 1'b0;
    check("bp_next_frame_sum", out_sum8, 4);
    handshake();

    // Abort after two +30 terms with an input present on the clear cycle.
    drive(1'b0, 1'b1, 4'd14);
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_out_valid", out_valid8, 0);
    check("clr_in_ready", in_ready8, 1);
    drive(1'b1, 1'b1, 4'd1);
    tick(); tick(); tick();
    check("clr_three_accepts", out_valid8, 0);
    tick();
    in_valid = 1'b0;
    check("clr_frame_valid", out_valid8, 1);
    check("clr_frame_sum", out_sum8, 4);
    check("clr_frame_ovf6", out_ovf6, 0);
    handshake();

    // Reset while holding an overflowed 6-bit frame.
    drive(1'b0, 1'b1, 4'd14);
    tick(); tick(); tick(); tick();
    in_valid = 1'b0;
    tick();
    check("rst_pre_valid", out_valid6, 1);
    check("rst_pre_ovf6", out_ovf6, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_hold_valid", out_valid8, 0);
    check("rst_hold_sum", out_sum8, 0);
    check("rst_hold_ovf6", out_ovf6, 0);
    check("rst_hold_sum6", out_sum6, 0);
    check("rst_hold_ready", in_ready8, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
